// File: rtl/beep_sequencer.sv
// Key-driven melody controller: debounced keys launch four-note phrases on a square-wave buzzer.
// Optional macro BEEP_REPEAT_EN: a held key replays its phrase back-to-back instead of stopping.
module beep_sequencer #(
  parameter int unsigned DEBOUNCE_CYC = 32'd1_000_000,
  parameter int unsigned NOTE_CYC     = 32'd12_500_000,
  parameter int unsigned GAP_CYC      = 32'd1_250_000,
  parameter int unsigned HP_SHIFT     = 32'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key,
  output logic       beep,
  output logic [4:0] led,
  output logic       busy
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_TONE = 2'd1, ST_GAP = 2'd2} state_t;

  localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYC - 32'd1);
  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYC - 32'd1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 32'd1);

  function automatic logic [2:0] note_code(input logic [2:0] ph, input logic [1:0] idx);
    logic [11:0] row;
    logic [2:0]  code;
    case (ph)
      3'd0:    row = {3'd1, 3'd2, 3'd3, 3'd4};
      3'd1:    row = {3'd5, 3'd4, 3'd3, 3'd2};
      3'd2:    row = {3'd1, 3'd3, 3'd5, 3'd0};
      3'd3:    row = {3'd6, 3'd6, 3'd0, 3'd6};
      3'd4:    row = {3'd7, 3'd5, 3'd3, 3'd1};
      default: row = 12'd0;
    endcase
    case (idx)
      2'd0:    code = row[11:9];
      2'd1:    code = row[8:6];
      2'd2:    code = row[5:3];
      2'd3:    code = row[2:0];
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  function automatic logic [31:0] half_period(input logic [2:0] code);
    logic [31:0] hp;
    case (code)
      3'd1:    hp = 32'd95556;
      3'd2:    hp = 32'd85131;
      3'd3:    hp = 32'd75843;
      3'd4:    hp = 32'd71586;
      3'd5:    hp = 32'd63776;
      3'd6:    hp = 32'd56818;
      3'd7:    hp = 32'd50619;
      default: hp = 32'd0;
    endcase
    return hp >> HP_SHIFT;
  endfunction

  logic [4:0]  key_meta_r, key_sync_r, db_r, db_d_r;
  logic [31:0] db_cnt_r [5];
  logic [4:0]  pe_s;
  logic        win_valid_s, restart_s, hold_s, tone_entry_s;
  logic [2:0]  win_idx_s;
  state_t      state_r, state_n;
  logic [2:0]  phrase_r, phrase_n;
  logic [1:0]  note_r, note_n;
  logic [31:0] dur_r, dur_n, tcnt_r, tcnt_n, hp_n_s;
  logic [2:0]  code_n_s;
  logic        beep_r, beep_n, busy_r;
  logic [4:0]  led_r;

  // Key synchronizer and per-key stability counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_r <= 5'h1F;
      key_sync_r <= 5'h1F;
      db_r       <= 5'h1F;
      db_d_r     <= 5'h1F;
      for (int i = 0; i < 5; i++) db_cnt_r[i] <= 32'd0;
    end else begin
      key_meta_r <= key;
      key_sync_r <= key_meta_r;
      db_d_r     <= db_r;
      for (int i = 0; i < 5; i++) begin
        if (key_sync_r[i] == db_r[i]) begin
          db_cnt_r[i] <= 32'd0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_r[i]     <= key_sync_r[i];
          db_cnt_r[i] <= 32'd0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 32'd1;
        end
      end
    end
  end

  assign pe_s = db_d_r & ~db_r;

`ifdef BEEP_REPEAT_EN
  assign hold_s = ~db_r[phrase_r];
`else
  assign hold_s = 1'b0;
`endif

  // Lowest-index press wins; a press for a different phrase preempts playback
  always_comb begin
    win_valid_s = 1'b1;
    win_idx_s   = 3'd0;
    casez (pe_s)
      5'b????1: win_idx_s = 3'd0;
      5'b???10: win_idx_s = 3'd1;
      5'b??100: win_idx_s = 3'd2;
      5'b?1000: win_idx_s = 3'd3;
      5'b10000: win_idx_s = 3'd4;
      default:  win_valid_s = 1'b0;
    endcase
    restart_s = win_valid_s && (state_r != ST_IDLE) && (win_idx_s != phrase_r);
  end

  // Phrase sequencer next-state logic
  always_comb begin
    state_n  = state_r;
    phrase_n = phrase_r;
    note_n   = note_r;
    dur_n    = dur_r + 32'd1;
    if (restart_s || (state_r == ST_IDLE && win_valid_s)) begin
      state_n  = ST_TONE;
      phrase_n = win_idx_s;
      note_n   = 2'd0;
      dur_n    = 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: dur_n = 32'd0;
        ST_TONE: begin
          if (dur_r == NOTE_LAST) begin
            state_n = ST_GAP;
            dur_n   = 32'd0;
          end else begin
            dur_n = dur_r + 32'd1;
          end
        end
        ST_GAP: begin
          if (dur_r == GAP_LAST) begin
            dur_n = 32'd0;
            if (note_r != 2'd3) begin
              note_n  = note_r + 2'd1;
              state_n = ST_TONE;
            end else if (hold_s) begin
              note_n  = 2'd0;
              state_n = ST_TONE;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            dur_n = dur_r + 32'd1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          dur_n   = 32'd0;
        end
      endcase
    end
  end

  // Tone generator: restarts silent on every TONE entry, silent outside TONE and on rests
  always_comb begin
    tone_entry_s = (state_n == ST_TONE) && ((state_r != ST_TONE) || restart_s);
    code_n_s     = note_code(phrase_n, note_n);
    hp_n_s       = half_period(code_n_s);
    if ((state_n != ST_TONE) || tone_entry_s || (code_n_s == 3'd0)) begin
      tcnt_n = 32'd0;
      beep_n = 1'b0;
    end else if (tcnt_r == hp_n_s - 32'd1) begin
      tcnt_n = 32'd0;
      beep_n = ~beep_r;
    end else begin
      tcnt_n = tcnt_r + 32'd1;
      beep_n = beep_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      phrase_r <= 3'd0;
      note_r   <= 2'd0;
      dur_r    <= 32'd0;
      tcnt_r   <= 32'd0;
      beep_r   <= 1'b0;
      busy_r   <= 1'b0;
      led_r    <= 5'd0;
    end else begin
      state_r  <= state_n;
      phrase_r <= phrase_n;
      note_r   <= note_n;
      dur_r    <= dur_n;
      tcnt_r   <= tcnt_n;
      beep_r   <= beep_n;
      busy_r   <= (state_n != ST_IDLE);
      led_r    <= (state_n != ST_IDLE) ? 5'(5'd1 << phrase_n) : 5'd0;
    end
  end

  assign beep = beep_r;
  assign busy = busy_r;
  assign led  = led_r;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer: vector table for a clean press plus hand sequences for corners.
module tb_beep_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] key = 5'h1F;
  logic       beep;
  logic [4:0] led;
  logic       busy;

  int errors = 0;
  int checks = 0;

  beep_sequencer #(
    .DEBOUNCE_CYC(32'd4),
    .NOTE_CYC    (32'd1000),
    .GAP_CYC     (32'd100),
    .HP_SHIFT    (32'd10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .key  (key),
    .beep (beep),
    .led  (led),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] key;
    int         adv;
    logic       exp_busy;
    logic [4:0] exp_led;
    logic       exp_beep;
  } vec_t;

  vec_t vecs[13];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic eb, input logic [4:0] el, input logic ep);
    check({tag, "_busy"}, 32'(busy), 32'(eb));
    check({tag, "_led"},  32'(led),  32'(el));
    check({tag, "_beep"}, 32'(beep), 32'(ep));
  endtask

  initial begin
    int highs;
    // Times are edges after the key change; TONE entry is edge 7, C4 toggles every 93, D4 every 83
    vecs[0]  = '{5'h1E, 6,    1'b0, 5'h00, 1'b0};
    vecs[1]  = '{5'h1E, 1,    1'b1, 5'h01, 1'b0};
    vecs[2]  = '{5'h1E, 13,   1'b1, 5'h01, 1'b0};
    vecs[3]  = '{5'h1F, 79,   1'b1, 5'h01, 1'b0};
    vecs[4]  = '{5'h1F, 1,    1'b1, 5'h01, 1'b1};
    vecs[5]  = '{5'h1F, 92,   1'b1, 5'h01, 1'b1};
    vecs[6]  = '{5'h1F, 1,    1'b1, 5'h01, 1'b0};
    vecs[7]  = '{5'h1F, 743,  1'b1, 5'h01, 1'b1};
    vecs[8]  = '{5'h1F, 71,   1'b1, 5'h01, 1'b0};
    vecs[9]  = '{5'h1F, 182,  1'b1, 5'h01, 1'b0};
    vecs[10] = '{5'h1F, 1,    1'b1, 5'h01, 1'b1};
    vecs[11] = '{5'h1F, 3216, 1'b1, 5'h01, 1'b0};
    vecs[12] = '{5'h1F, 1,    1'b0, 5'h00, 1'b0};

    step(3);
    check_out("reset", 1'b0, 5'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check_out("idle", 1'b0, 5'h00, 1'b0);

    // Clean press of key 0
    for (int i = 0; i < 13; i++) begin
      key = vecs[i].key;
      step(vecs[i].adv);
      check_out($sformatf("clean_v%0d", i), vecs[i].exp_busy, vecs[i].exp_led, vecs[i].exp_beep);
    end

    // Bounce on key 2 never qualifies
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      key = (i < 40 && ((i / 2) % 2 == 0)) ? 5'h1B : 5'h1F;
      step(1);
      if (busy) highs++;
    end
    check("bounce_busy_cycles", 32'(highs), 32'd0);
    check("bounce_led", 32'(led), 32'd0);

    // Keys 1 and 3 together: key 1 wins (G4 half period 62)
    key = 5'b10101;
    step(7);
    check_out("simul_start", 1'b1, 5'b00010, 1'b0);
    step(13);
    key = 5'h1F;
    step(48);
    check_out("simul_pre_rise", 1'b1, 5'b00010, 1'b0);
    step(1);
    check_out("simul_rise", 1'b1, 5'b00010, 1'b1);
    step(4338);
    check_out("simul_end", 1'b0, 5'h00, 1'b0);

    // Preemption by key 3 mid-phrase, then its rest note
    key = 5'h1E;
    step(7);
    check_out("pre_start", 1'b1, 5'h01, 1'b0);
    step(13);
    key = 5'h1F;
    step(1487);
    key = 5'h17;
    step(6);
    check("pre_before_led", 32'(led), 32'h01);
    step(1);
    check_out("pre_restart", 1'b1, 5'b01000, 1'b0);
    step(54);
    check("pre_a4_pre_rise", 32'(beep), 32'd0);
    step(1);
    check("pre_a4_rise", 32'(beep), 32'd1);
    key = 5'h1F;
    step(2145);
    highs = 0;
    for (int i = 0; i < 1000; i++) begin
      if (beep) highs++;
      step(1);
    end
    check("rest_beep_cycles", 32'(highs), 32'd0);
    check_out("rest_after", 1'b1, 5'b01000, 1'b0);
    step(154);
    check("pre_n4_pre_rise", 32'(beep), 32'd0);
    step(1);
    check("pre_n4_rise", 32'(beep), 32'd1);
    step(1044);
    check("pre_last_gap_busy", 32'(busy), 32'd1);
    step(1);
    check_out("pre_end", 1'b0, 5'h00, 1'b0);

    // Asynchronous reset mid-TONE with beep high
    key = 5'h1E;
    step(7);
    step(13);
    key = 5'h1F;
    step(80);
    check_out("rst_before", 1'b1, 5'h01, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 1'b0, 5'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    check_out("rst_idle", 1'b0, 5'h00, 1'b0);
    key = 5'h1B;
    step(7);
    check_out("rst_press", 1'b1, 5'b00100, 1'b0);
    step(13);
    key = 5'h1F;
    step(79);
    check("rst_c4_pre_rise", 32'(beep), 32'd0);
    step(1);
    check("rst_c4_rise", 32'(beep), 32'd1);
    step(4307);
    check_out("rst_end", 1'b0, 5'h00, 1'b0);

`ifdef BEEP_REPEAT_EN
    // Held key 4 repeats phrase 4 (B4 half period 49) until released
    key = 5'h0F;
    step(7);
    check_out("rep_start", 1'b1, 5'b10000, 1'b0);
    step(4400);
    check_out("rep_second", 1'b1, 5'b10000, 1'b0);
    step(48);
    check("rep_pre_rise", 32'(beep), 32'd0);
    step(1);
    check("rep_rise", 32'(beep), 32'd1);
    step(5544);
    key = 5'h1F;
    step(3206);
    check("rep_last_busy", 32'(busy), 32'd1);
    step(1);
    check_out("rep_end", 1'b0, 5'h00, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/beep_sequencer.md
# beep_sequencer

Key-driven melody controller for the board buzzer and the five status LEDs. It debounces the five active-low push keys and arbitrates simultaneous presses. Each press plays a fixed four-note phrase by sequencing an internal square-wave tone generator. It sits between the raw key pins and the `beep`/`led` pins, replacing direct key-to-frequency decoding with timed, glitch-free playback.

## Interface
- `DEBOUNCE_CYC`, 1_000_000 — cycles a synchronized key level must be stable to be accepted (20 ms at 50 MHz).
- `NOTE_CYC`, 12_500_000 — duration of each note or rest, in cycles.
- `GAP_CYC`, 1_250_000 — silent gap after each note, in cycles.
- `HP_SHIFT`, 0 — right shift applied to every half-period table entry; used for simulation speed-up.
- `clk` input 1 — system clock, 50 MHz.
- `rst_n` input 1 — reset, asynchronous and active-low; one clock domain.
- `key` input 5 — push keys, active-low, asynchronous to `clk`.
- `beep` output 1 — square wave to the buzzer.
- `led` output 5 — one-hot indication of the phrase currently playing.
- `busy` output 1 — high while a phrase is playing.

## Operation
- **Input conditioning**
  - Each `key[i]` passes through a 2-FF synchronizer, then a per-key stability counter (32-bit).
  - The debounced level `db[i]` updates only after `DEBOUNCE_CYC` consecutive equal synchronized samples.
  - A press event `pe[i]` is a one-cycle pulse on a 1→0 transition of `db[i]`.
- **Arbitration:** if several `pe` bits are high in the same cycle, the lowest index wins and the others are discarded.
- **Phrase ROM:** 5 phrases × 4 note codes. Note codes are 0 = rest, 1..7 = C4 D4 E4 F4 G4 A4 B4.
  - Half periods for codes 1..7: 95556, 85131, 75843, 71586, 63776, 56818, 50619.
  - Each entry is shifted right by `HP_SHIFT`.
  - Phrase 0: 1,2,3,4. Phrase 1: 5,4,3,2. Phrase 2: 1,3,5,0. Phrase 3: 6,6,0,6. Phrase 4: 7,5,3,1.
- **FSM states**
  - IDLE → TONE on any winning `pe`: latch the phrase index, set note index = 0, clear the duration counter.
  - TONE: lasts `NOTE_CYC` cycles, then → GAP.
  - GAP: lasts `GAP_CYC` cycles. At the end, if note index < 3 then increment it and → TONE; else → IDLE.
- **Preemption**
  - A `pe` in TONE/GAP for a different phrase restarts: the new phrase is latched, note index = 0, state → TONE.
  - A `pe` for the phrase already playing is ignored.
- **Tone generator**
  - A 32-bit counter runs only in TONE with a nonzero note code.
  - When the counter reaches half_period−1, it wraps to 0 and `beep` toggles.
  - The counter clears and `beep` is forced to 0 on every TONE entry, in GAP, in IDLE, and for rest notes.
- **Outputs:** `led` = one-hot of the latched phrase while `busy`, otherwise 0. `busy` = 1 in TONE/GAP.

## Timing
- **Reset:** all-zero state, IDLE, `beep`=0, `led`=0, `busy`=0, debounced levels = 1 (released), counters 0. Reset may be asserted at any time, including mid-phrase, and takes effect immediately.
- **Key to press event:** a key low from cycle 0 gives `pe` at cycle 2 + `DEBOUNCE_CYC` (±1 for input phase).
- **Press event to playback:** `pe` at cycle N gives state TONE, `busy`=1 and `led` valid at N+1. The first `beep` rise is at N+1+half_period.
- **Phrase length:** exactly 4·(`NOTE_CYC`+`GAP_CYC`) cycles from TONE entry to IDLE. `busy` falls on the cycle after the final GAP cycle.
- **Key release:** releasing the key has no effect on playback. Holding the key produces no further events.

## Configuration
- `BEEP_REPEAT_EN`
  - Defined: at the end of the last GAP, if `db` of the playing key is still 0 (held), the FSM restarts the same phrase at note 0 instead of going to IDLE. `busy` stays 1 throughout.
  - Undefined: each press plays the phrase exactly once.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `NOTE_CYC`=1000, `GAP_CYC`=100, `HP_SHIFT`=10.

1. **Clean press:** hold `key`=5'b11110 for 20 cycles → `busy`/`led`=5'b00001 for 4400 cycles. `beep` toggles every 93 cycles in note 1 (C4: 95556>>10) and is 0 in gaps; then IDLE.
2. **Bounce rejection:** `key[2]` toggles every 2 cycles for 40 cycles, then settles high → no press event, `busy` stays 0.
3. **Simultaneous press:** `key`=5'b10101 (keys 1 and 3 pressed) → phrase 1 plays, `led`=5'b00010.
4. **Preemption and rests:** press key 0, then press key 3 at 1500 cycles in → restart on phrase 3 the next cycle, `led`=5'b01000. Note 3 is a rest: `beep`=0 for its full 1000 cycles.
5. **Async reset:** pull `rst_n` low mid-TONE → `beep`, `busy` and `led` are 0 in the same cycle. After release, the block is IDLE and the next press plays from note 0.
6. **Repeat (`BEEP_REPEAT_EN` defined):** hold key 4 for 10000 cycles → phrase 4 repeats back-to-back. After release, the current pass completes, then IDLE.
